// File: rtl/uart_word_tx.sv
// UART transmitter fed by a word FIFO: each buffered word leaves as WORD_BYTES back-to-back frames, LSB byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit of every frame.
module uart_word_tx #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int WORD_BYTES       = 4,
    parameter int DEPTH            = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        wr_en,
    input  logic [8*WORD_BYTES-1:0]     wr_data,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        txd,
    output logic                        busy,
    output logic                        idle
);

    localparam int DATA_W  = 8 * WORD_BYTES;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int TMR_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BYTE_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [2:0]        bit_idx_q;
    logic [BYTE_W-1:0] byte_idx_q;
    logic [DATA_W-1:0] shreg_q;

    logic push, pop, bit_end, last_byte, next_byte;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = wr_en && !full;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign bit_end   = (tmr_q == TMR_W'(BIT_CYC - 1));
    assign last_byte = (byte_idx_q == BYTE_W'(WORD_BYTES - 1));
    assign next_byte = (state_q == STOP) && bit_end && !last_byte;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);
    assign idle     = (count_q == '0) && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        txd     = 1'b1;
        case (state_q)
            IDLE: begin
                if (pop) state_d = START;
            end
            START: begin
                txd = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                txd = shreg_q[bit_idx_q];
                if (bit_end && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd = even_parity(shreg_q[7:0]);
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                txd = 1'b1;
                if (bit_end) state_d = last_byte ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, bit timer, indices, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Every state exit happens on bit_end, so this also restarts the timer on state entry
            if (state_q == IDLE || bit_end) tmr_q <= '0;
            else                            tmr_q <= tmr_q + 1'b1;
            if (pop) begin
                bit_idx_q  <= '0;
                byte_idx_q <= '0;
            end else if (state_q == DATA && bit_end) begin
                bit_idx_q  <= bit_idx_q + 3'd1;
            end else if (next_byte) begin
                byte_idx_q <= byte_idx_q + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_en && full) overflow_q <= 1'b1;
        end
    end

    // Datapath: FIFO storage and the word shift register
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop)            shreg_q <= mem[rd_ptr];
        else if (next_byte) shreg_q <= shreg_q >> 8;
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with H=2, WORD_BYTES=2, DEPTH=4; txd is logged per cycle and compared to hand-written frames.
module tb_uart_word_tx;

    localparam int H  = 2;
    localparam int WB = 2;
    localparam int D  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam int BITC     = 2 * H;
    localparam int WORD_CYC = WB * FL * BITC;
    localparam int LOGN     = 8192;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full, overflow, txd, busy, idle;
    logic [2:0]  count;

    uart_word_tx #(.CLK_PER_HALF_BIT(H), .WORD_BYTES(WB), .DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .count(count), .overflow(overflow),
        .txd(txd), .busy(busy), .idle(idle)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic txd_log [LOGN];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < LOGN) txd_log[cyc] = txd;

    typedef struct {
        logic [15:0] word;
        string       f0;
        string       f1;
    } vec_t;
    vec_t vec [6];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic check_word(input int start, input int v);
        string f;
        for (int b = 0; b < WB; b++) begin
            f = (b == 0) ? vec[v].f0 : vec[v].f1;
            for (int bi = 0; bi < FL; bi++) begin
                for (int k = 0; k < BITC; k++) begin
                    check($sformatf("txd_w%0d_byte%0d_bit%0d_c%0d", v, b, bi, k),
                          {31'd0, txd_log[start + b*FL*BITC + bi*BITC + k]},
                          {31'd0, f.getc(bi) == 8'h31});
                end
            end
        end
    endtask

    int n, s0, rst_cyc;
    int   exp_cnt  [6] = '{1, 1, 2, 3, 4, 4};
    logic exp_full [6] = '{0, 0, 0, 0, 1, 1};
    logic quiet;

    initial begin
        // Frames as sent on the line: start, data LSB first, [parity], stop
`ifdef UART_TX_PARITY_EN
        vec[0] = '{16'hA55A, "00101101001", "01010010101"};
        vec[1] = '{16'h0000, "00000000001", "00000000001"};
        vec[2] = '{16'hFFFF, "01111111101", "01111111101"};
        vec[3] = '{16'h8001, "01000000011", "00000000111"};
        vec[4] = '{16'h3C96, "00110100101", "00011110001"};
        vec[5] = '{16'h0003, "01100000001", "00000000001"};
`else
        vec[0] = '{16'hA55A, "0010110101", "0101001011"};
        vec[1] = '{16'h0000, "0000000001", "0000000001"};
        vec[2] = '{16'hFFFF, "0111111111", "0111111111"};
        vec[3] = '{16'h8001, "0100000001", "0000000011"};
        vec[4] = '{16'h3C96, "0011010011", "0001111001"};
        vec[5] = '{16'h0003, "0110000001", "0000000001"};
`endif

        // Reset
        rstn = 1'b0;
        repeat (3) step();
        check("rst_txd", {31'd0, txd}, 1);
        check("rst_idle", {31'd0, idle}, 1);
        check("rst_count", {29'd0, count}, 0);
        check("rst_full", {31'd0, full}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rstn = 1'b1;
        step();

        // Single words from the table
        for (int v = 0; v < 6; v++) begin
            n = cyc;
            wr_en = 1'b1; wr_data = vec[v].word;
            step();
            wr_en = 1'b0;
            check($sformatf("v%0d_count_n1", v), {29'd0, count}, 1);
            check($sformatf("v%0d_busy_n1", v), {31'd0, busy}, 0);
            check($sformatf("v%0d_txd_n1", v), {31'd0, txd}, 1);
            step();
            check($sformatf("v%0d_busy_n2", v), {31'd0, busy}, 1);
            check($sformatf("v%0d_count_n2", v), {29'd0, count}, 0);
            steps_to(n + 1 + WORD_CYC);
            check($sformatf("v%0d_idle_last_stop", v), {31'd0, idle}, 0);
            steps_to(n + 2 + WORD_CYC);
            check($sformatf("v%0d_idle_after", v), {31'd0, idle}, 1);
            check($sformatf("v%0d_busy_after", v), {31'd0, busy}, 0);
            check_word(n + 2, v);
        end

        // Fill and overflow while the first word is on the line
        n = cyc;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = vec[i].word;
            step();
            check($sformatf("fill%0d_count", i), {29'd0, count}, exp_cnt[i]);
            check($sformatf("fill%0d_full", i), {31'd0, full}, {31'd0, exp_full[i]});
            check($sformatf("fill%0d_overflow", i), {31'd0, overflow}, (i == 5) ? 1 : 0);
        end
        wr_en = 1'b0;

        // Push into the pop cycle while full
        steps_to(n + 2 + WORD_CYC);
        check("popcyc_busy", {31'd0, busy}, 0);
        check("popcyc_count", {29'd0, count}, 4);
        check("popcyc_full", {31'd0, full}, 1);
        wr_en = 1'b1; wr_data = 16'hDEAD;
        step();
        wr_en = 1'b0;
        check("popcyc_next_count", {29'd0, count}, 3);
        check("popcyc_next_full", {31'd0, full}, 0);
        check("popcyc_next_overflow", {31'd0, overflow}, 1);
        check("popcyc_next_busy", {31'd0, busy}, 1);

        s0 = n + 2;
        steps_to(s0 + 5 * (WORD_CYC + 1) - 1);
        check("fill_idle_end", {31'd0, idle}, 1);
        for (int j = 0; j < 5; j++) begin
            check_word(s0 + j * (WORD_CYC + 1), j);
            if (j > 0) check($sformatf("gap%0d_txd", j), {31'd0, txd_log[s0 + j*(WORD_CYC + 1) - 1]}, 1);
        end
        quiet = 1'b1;
        for (int i = 0; i < 3 * WORD_CYC; i++) begin
            step();
            if (txd !== 1'b1 || idle !== 1'b1) quiet = 1'b0;
        end
        check("fill_dropped_not_sent", {31'd0, quiet}, 1);

        // Reset during DATA of byte 1, with a second word queued
        n = cyc;
        wr_en = 1'b1; wr_data = vec[0].word;
        step();
        wr_data = vec[1].word;
        step();
        wr_en = 1'b0;
        rst_cyc = n + 2 + FL * BITC + 2 * BITC;
        steps_to(rst_cyc);
        check("midrst_txd_before", {31'd0, txd}, 0);
        check("midrst_busy_before", {31'd0, busy}, 1);
        check("midrst_count_before", {29'd0, count}, 1);
        rstn = 1'b0;
        step();
        check("midrst_txd", {31'd0, txd}, 1);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_count", {29'd0, count}, 0);
        check("midrst_idle", {31'd0, idle}, 1);
        check("midrst_overflow", {31'd0, overflow}, 0);
        rstn = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 2 * WORD_CYC; i++) begin
            step();
            if (txd !== 1'b1 || idle !== 1'b1) quiet = 1'b0;
        end
        check("midrst_nothing_sent", {31'd0, quiet}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised UART transmitter with an integrated word FIFO. It replaces the byte-only transmit path. Producers push whole multi-byte words in one cycle. The block buffers up to DEPTH words and serialises each word as WORD_BYTES back-to-back 8N1 frames on `txd`. It sits between the core's I/O store path and the board TX pin, and reports drain completion for program-end detection.

## Interface
Parameters:
- CLK_PER_HALF_BIT, 5208, clk cycles per half UART bit; one bit lasts 2*CLK_PER_HALF_BIT cycles; must be ≥1.
- WORD_BYTES, 4, bytes per FIFO word; ≥1.
- DEPTH, 16, FIFO depth in words; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- wr_en  in  1  push request; accepted when `full`=0 in the same cycle.
- wr_data  in  8*WORD_BYTES  word to push.
- full  out  1  FIFO holds DEPTH words.
- count  out  $clog2(DEPTH)+1  words currently buffered; excludes the word being serialised.
- overflow  out  1  sticky; set when wr_en=1 while full=1.
- txd  out  1  serial line; idles high.
- busy  out  1  a word is being serialised.
- idle  out  1  count==0 && busy==0; this is the drain-complete flag.

## Operation
- FIFO: circular buffer with wr_ptr/rd_ptr plus count.
  - Write is gated by the registered `full` of the current cycle.
  - A rejected write drops the data, sets `overflow`, and leaves pointers unchanged.
  - A write and a pop in the same cycle leave `count` unchanged. Both pointers advance and wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE with count≠0: pop the head word into the shift register, set byte index=0, set busy=1, go to START.
- START: txd=0 for one bit period, then DATA.
- DATA: 8 bits, LSB first, one bit period each; then PARITY or STOP.
- STOP: txd=1 for one bit period.
  - At the end of the period, if byte index < WORD_BYTES-1: increment the index, shift to the next byte, go to START. There is no gap between bytes.
  - Otherwise go to IDLE and set busy=0.
- Byte order: byte 0 is wr_data[7:0], sent first (little-endian).
- Bit timer: counter 0..2*CLK_PER_HALF_BIT-1. It restarts on every state entry and does not wrap into the next bit without a state or bit-index update.

## Timing
- Reset values: txd=1, full=0, count=0, overflow=0, busy=0, idle=1. FSM=IDLE, pointers=0.
- Reset mid-frame: txd=1 from the cycle after rstn is sampled low. The FIFO contents and the in-flight word are discarded.
- Push: wr_en high in cycle N gives count+1 and an updated full in cycle N+1.
- Pop latency:
  - First word written at cycle N is popped at cycle N+1, the first cycle count≠0 is visible.
  - busy=1 and the start bit appear on txd from cycle N+2.
- Word duration with H=CLK_PER_HALF_BIT: WORD_BYTES*10*2H cycles (11 with parity) from first start-bit cycle to last stop-bit cycle inclusive.
- Inter-word gap: after the last stop bit, the FSM spends one IDLE cycle, popping if non-empty. The next start bit begins the cycle after, so txd=1 for exactly 1 extra cycle between consecutive words.
- idle rises in the first cycle after the last stop bit completes with the FIFO empty.
- full=1 with a simultaneous pop: the write is still rejected (full is registered); full clears the next cycle.

## Configuration
- UART_TX_PARITY_EN defined:
  - An even-parity bit (XOR of the 8 data bits) is sent in state PARITY, one bit period, between DATA and STOP.
  - Frame = 11 bits.
- UART_TX_PARITY_EN undefined:
  - PARITY state and logic are absent.
  - Frame = 10 bits (8N1).

## Test plan
All scenarios use CLK_PER_HALF_BIT=2 (bit = 4 cycles), WORD_BYTES=2, DEPTH=4, no parity unless stated.
- Reset: hold rstn=0 for 3 cycles → txd=1, idle=1, count=0, full=0, overflow=0.
- Single word: push 16'hA55A at cycle N → start bit at N+2. txd carries frame 5A (0,0,1,0,1,1,0,1,0,1), then A5 with no gap. Total 80 cycles; idle=1 at N+82.
- Fill and overflow: push 6 words on consecutive cycles while the first is serialising.
  - full=1 once count=4.
  - The 6th push is rejected and overflow=1.
  - The 5 accepted words are emitted in order, with a 1-cycle txd-high gap between words.
- Full with simultaneous pop: with count=4, push again in the pop cycle → write rejected, count=3 next cycle, overflow=1.
- Reset mid-frame: assert rstn=0 during the DATA of byte 1 → txd=1 next cycle; after release, idle=1 and nothing is sent.
- Parity build: with UART_TX_PARITY_EN defined, push 16'h0003 → byte 03 frame has parity=0 and byte 00 frame has parity=0. Total 88 cycles.
